// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial receiver: FSM states, parity modes and
// the expected-parity helper.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_e;

  localparam int NONE = 0;
  localparam int EVEN = 1;
  localparam int ODD  = 2;

  function automatic logic expected_parity(input logic data_xor, input int mode);
    case (mode)
      EVEN:    return data_xor;
      ODD:     return ~data_xor;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/serial_rx_baud.sv
// Mid-bit sample timer: a restart schedules the first tick half a bit after
// the synchronised start edge, then one tick every CLKS_PER_BIT cycles.
module serial_rx_baud #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  // The restart is registered one cycle after the edge appears on the
  // synchronised line, and the tick acts one cycle after reaching zero.
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 2);

  logic [CW-1:0] cnt_d, cnt_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (restart_i)          cnt_d = HALF_LOAD;
    else if (cnt_q == '0)   cnt_d = FULL_LOAD;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/serial_rx.sv
// Asynchronous serial receiver: synchroniser, frame FSM with break detection,
// and a handshaked output register with sticky overrun.
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 RX_D,
  input  logic                 READY,
  output logic [DATA_BITS-1:0] BYTEOUT,
  output logic                 LOAD,
  output logic                 PARITY_ERR,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN,
  output logic                 BUSY
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rx_prev_q;
  logic [1:0]           settle_q;
  logic                 rx_s, fall, restart, tick, stop_bad;
  rx_state_e            state_q;
  logic [3:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_err_q, frm_err_q, done_q;
  logic [DATA_BITS-1:0] byteout_q;
  logic                 load_q, perr_q, ferr_q, overrun_q;

  assign rx_s = sync_q[1];
  // Edges are ignored until the reset-forced 1s have left the synchroniser
  // and edge register, so a line held low at release cannot start a frame.
  assign fall     = (settle_q == 2'd3) && rx_prev_q && !rx_s;
  assign restart  = (state_q == S_IDLE) && fall;
  assign stop_bad = frm_err_q | ~rx_s;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      settle_q  <= '0;
    end else begin
      sync_q    <= {sync_q[0], RX_D};
      rx_prev_q <= rx_s;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  serial_rx_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .restart_i(restart),
    .tick_o   (tick)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (fall) begin
          state_q   <= S_START;
          bit_cnt_q <= '0;
          par_err_q <= 1'b0;
          frm_err_q <= 1'b0;
        end
        S_START: if (tick) state_q <= rx_s ? S_IDLE : S_DATA;
        S_DATA: if (tick) begin
          shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_q <= '0;
            state_q   <= (PARITY_MODE != NONE) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        S_PARITY: if (tick) begin
          par_err_q <= (rx_s != expected_parity(^shreg_q, PARITY_MODE));
          state_q   <= S_STOP;
        end
        S_STOP: if (tick) begin
          frm_err_q <= stop_bad;
          if (bit_cnt_q == LAST_STOP) begin
            done_q    <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= (stop_bad && shreg_q == '0) ? S_BREAK : S_IDLE;
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        S_BREAK: if (rx_s) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output register: a finished frame loads when empty or when the held
  // word is being accepted this same cycle; otherwise it is dropped.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      byteout_q <= '0;
      load_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else if (done_q) begin
      if (!load_q || READY) begin
        byteout_q <= shreg_q;
        perr_q    <= par_err_q;
        ferr_q    <= frm_err_q;
        load_q    <= 1'b1;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (load_q && READY) begin
      load_q <= 1'b0;
    end
  end

  assign BYTEOUT    = byteout_q;
  assign LOAD       = load_q;
  assign PARITY_ERR = perr_q;
  assign FRAME_ERR  = ferr_q;
  assign OVERRUN    = overrun_q;
  assign BUSY       = (state_q != S_IDLE);

endmodule
